ifq_line_buffer: RTL



---
 rtl/ifq_line_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ifq_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ifq_line_buffer
// Description : Circular queue of fetched I-cache lines that presents one
//               instruction per cycle to decode. Optional same-cycle bypass of
//               an empty-queue push is enabled with macro IFQ_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_line_buffer #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     line_valid,
    input  logic [4*INSTR_W-1:0]     line_data,
    input  logic [PC_W-1:0]          line_pc,
    output logic                     line_ready,
    output logic                     instr_valid,
    output logic [INSTR_W-1:0]       instr_out,
    output logic [PC_W-1:0]          pc_out,
    input  logic                     instr_read,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam int                 c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // Entry storage: line payload, upper PC bits and start-word offset
    logic [4*INSTR_W-1:0] r_data  [DEPTH];
    logic [PC_W-5:0]      r_pc_hi [DEPTH];
    logic [1:0]           r_start [DEPTH];

    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [1:0]           r_off;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_byp;
    logic                 w_byp_read;
    logic                 w_byp_consume;
    logic                 w_store;
    logic                 w_adv;
    logic                 w_pop;
    logic                 w_new_head;
    logic [1:0]           w_off_load;
    logic [c_ptr_w-1:0]   w_rd_next;
    logic [INSTR_W-1:0]   w_head_words [4];
    logic [INSTR_W-1:0]   w_line_words [4];

    for (genvar k = 0; k < 4; k++) begin : g_words
        assign w_head_words[k] = r_data[r_rd_ptr][k*INSTR_W +: INSTR_W];
        assign w_line_words[k] = line_data[k*INSTR_W +: INSTR_W];
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full);
    assign w_push  = line_valid & ~w_full & ~flush;

`ifdef IFQ_BYPASS_EN
    assign w_byp   = w_empty & w_push;
`else
    assign w_byp   = 1'b0;
    logic  w_unused_pc_lo;
    assign w_unused_pc_lo = &{1'b0, line_pc[1:0]};
`endif

    assign w_byp_read    = w_byp & instr_read;
    // A bypassed line whose only useful word is consumed never enters storage
    assign w_byp_consume = w_byp_read & (line_pc[3:2] == 2'd3);
    assign w_store       = w_push & ~w_byp_consume;

    assign w_adv     = instr_read & ~w_empty & ~flush;
    assign w_pop     = w_adv & (r_off == 2'd3);
    assign w_rd_next = r_rd_ptr + c_ptr_one;

    // Pushed line becomes head when the queue is, or is about to become, empty
    assign w_new_head = w_store & (w_empty | (w_pop & (r_count == c_cnt_one)));
    assign w_off_load = w_byp_read ? (line_pc[3:2] + 2'd1) : line_pc[3:2];

    assign line_ready  = ~w_full;
    assign instr_valid = ~w_empty | w_byp;
    assign count       = r_count;

    always_comb begin
        instr_out = '0;
        pc_out    = '0;
        if (w_byp) begin
            instr_out = w_line_words[line_pc[3:2]];
            pc_out    = line_pc;
        end else if (!w_empty) begin
            instr_out = w_head_words[r_off];
            pc_out    = {r_pc_hi[r_rd_ptr], r_off, 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_off    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_off    <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end

            if (w_new_head) begin
                r_off <= w_off_load;
            end else if (w_pop) begin
                r_off <= r_start[w_rd_next];
            end else if (w_adv) begin
                r_off <= r_off + 2'd1;
            end

            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_data[r_wr_ptr]  <= line_data;
            r_pc_hi[r_wr_ptr] <= line_pc[PC_W-1:4];
            r_start[r_wr_ptr] <= line_pc[3:2];
        end
    end

endmodule
`default_nettype wire
